// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// The CPU pushes bytes through DATA (+0). A serialiser drains the FIFO LSB first,
// one BAUD_DIV-cycle slot per bit. STATUS (+1) and LEVEL (+2) are read back through
// a registered dout with one cycle of latency.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   addr      MMIO address
//   din       write data
//   write_en  write strobe, already qualified by chip select
//   dout      registered read data (valid the cycle after addr)
//   tx        serial output, idle high
//   busy      frame in flight or FIFO non-empty
//
// State table:
//   S_IDLE  | line idle (tx=1), waiting for a byte in the FIFO
//   S_START | start bit (tx=0) for BAUD_DIV cycles
//   S_DATA  | data bits 0..7, LSB first, BAUD_DIV cycles each
//   S_STOP  | stop bit (tx=1); chains straight into the next frame if data is queued
module uart_tx_mmio #(
  parameter logic [7:0] BASE_ADDR  = 8'h12,
  parameter int         data_width = 8,
  parameter int         BAUD_DIV   = 104,
  parameter int         FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            addr,
  input  logic [data_width-1:0] din,
  input  logic                  write_en,
  output logic [data_width-1:0] dout,
  output logic                  tx,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int                 DEPTH       = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL    = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE     = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE     = FIFO_AW'(1);
  localparam logic [15:0]        BAUD_LOAD   = 16'(BAUD_DIV - 1);
  localparam logic [7:0]         ADDR_DATA   = BASE_ADDR;
  localparam logic [7:0]         ADDR_STATUS = BASE_ADDR + 8'd1;
  localparam logic [7:0]         ADDR_LEVEL  = BASE_ADDR + 8'd2;

  logic [1:0]           state, state_nxt;
  logic [15:0]          baud_cnt, baud_nxt;
  logic [2:0]           bit_cnt, bit_nxt;
  logic [7:0]           shift, shift_nxt;
  logic                 tx_nxt;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count, count_nxt;
  logic                 overflow;

  logic                 empty, full, push_req, push_ok, pop, baud_done;
  logic [data_width-1:0] rd_data;

  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign baud_done = (baud_cnt == 16'd0);
  assign push_req  = write_en && (addr == ADDR_DATA);
  // The FSM only ever pops in IDLE or at the end of a stop bit.
  assign pop       = !empty && ((state == S_IDLE) || ((state == S_STOP) && baud_done));
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push_ok   = push_req && (!full || pop);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push_ok)
      count_nxt = count - CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_nxt = S_START;
          tx_nxt    = 1'b0;
          baud_nxt  = BAUD_LOAD;
          shift_nxt = mem[rd_ptr];
        end
      end
      S_START: begin
        if (baud_done) begin
          state_nxt = S_DATA;
          tx_nxt    = shift[0];
          baud_nxt  = BAUD_LOAD;
          bit_nxt   = 3'd0;
        end else begin
          baud_nxt = baud_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_nxt = BAUD_LOAD;
          if (bit_cnt == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
            bit_nxt   = bit_cnt + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt - 16'd1;
        end
      end
      default: begin
        if (baud_done) begin
          if (!empty) begin
            state_nxt = S_START;
            tx_nxt    = 1'b0;
            baud_nxt  = BAUD_LOAD;
            shift_nxt = mem[rd_ptr];
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
    end else begin
      state    <= state_nxt;
      tx       <= tx_nxt;
      busy     <= (state_nxt != S_IDLE) || (count_nxt != '0);
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      // A dropped push in the same cycle as a STATUS write leaves overflow set.
      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (write_en && (addr == ADDR_STATUS))
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_STATUS: rd_data = {4'b0, overflow, empty, full, busy};
      ADDR_LEVEL:  rd_data = {{(data_width-FIFO_AW-1){1'b0}}, count};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dout <= '0;
    else
      dout <= rd_data;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with BAUD_DIV=4, depth-4 FIFO.
module tb_uart_tx_mmio;

  localparam logic [7:0] BASE = 8'h12;

  logic       clk;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] din;
  logic       write_en;
  logic [7:0] dout;
  logic       tx;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_mmio #(
    .BASE_ADDR(BASE),
    .data_width(8),
    .BAUD_DIV(4),
    .FIFO_AW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .din(din),
    .write_en(write_en),
    .dout(dout),
    .tx(tx),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mmio_write(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    din = d;
    write_en = 1'b1;
    @(posedge clk); #1;
    write_en = 1'b0;
  endtask

  task automatic mmio_read(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    @(posedge clk); #1;
    d = dout;
  endtask

  // Called 1 time unit after the edge that starts slot `first` of a frame;
  // samples each of the remaining 40 bit-clock slots and returns 1 unit after
  // the edge that ends the frame.
  task automatic check_frame(input logic [7:0] b, input int first);
    logic exp_bit;
    for (int k = first; k < 40; k++) begin
      int j;
      j = k / 4;
      if (j == 0)
        exp_bit = 1'b0;
      else if (j == 9)
        exp_bit = 1'b1;
      else
        exp_bit = b[j-1];
      check($sformatf("tx_%02h_k%0d", b, k), {31'd0, tx}, {31'd0, exp_bit});
      if (k == 39)
        check($sformatf("busy_end_%02h", b), {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] rd;

  initial begin
    rst = 1'b0;
    addr = 8'h00;
    din = 8'h00;
    write_en = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    rst = 1'b1;
    mmio_read(BASE + 8'd1, rd);
    check("rst_status", {24'd0, rd}, 32'h04);
    mmio_read(BASE + 8'd2, rd);
    check("rst_level", {24'd0, rd}, 32'd0);

    // single byte
    mmio_write(BASE, 8'hA5);
    @(posedge clk); #1;
    check_frame(8'hA5, 0);
    check("single_busy_done", {31'd0, busy}, 32'd0);
    check("single_tx_idle", {31'd0, tx}, 32'd1);

    // back-to-back
    mmio_write(BASE, 8'h01);
    mmio_write(BASE, 8'h80);
    check("b2b_start", {31'd0, tx}, 32'd0);
    addr = BASE + 8'd2;
    @(posedge clk); #1;
    check("b2b_level", {24'd0, dout}, 32'd1);
    check_frame(8'h01, 1);
    check_frame(8'h80, 0);
    check("b2b_busy_done", {31'd0, busy}, 32'd0);

    // overflow
    for (int i = 0; i < 6; i++)
      mmio_write(BASE, 8'h10 + 8'(i));
    check_frame(8'h10, 4);
    for (int i = 1; i < 5; i++)
      check_frame(8'h10 + 8'(i), 0);
    check("ovf_busy_done", {31'd0, busy}, 32'd0);
    check("ovf_tx_idle", {31'd0, tx}, 32'd1);
    mmio_read(BASE + 8'd1, rd);
    check("ovf_status_set", {24'd0, rd}, 32'h0C);
    mmio_write(BASE + 8'd1, 8'h00);
    mmio_read(BASE + 8'd1, rd);
    check("ovf_status_clr", {24'd0, rd}, 32'h04);

    // address decode
    mmio_write(BASE + 8'd2, 8'h55);
    mmio_write(BASE + 8'd3, 8'h66);
    mmio_read(BASE + 8'd2, rd);
    check("dec_level", {24'd0, rd}, 32'd0);
    check("dec_busy", {31'd0, busy}, 32'd0);
    check("dec_tx", {31'd0, tx}, 32'd1);
    mmio_read(BASE + 8'd1, rd);
    check("dec_status", {24'd0, rd}, 32'h04);
    mmio_read(BASE + 8'd3, rd);
    check("dec_rd_plus3", {24'd0, rd}, 32'd0);
    mmio_read(BASE + 8'd1, rd);
    mmio_read(BASE, rd);
    check("dec_rd_data", {24'd0, rd}, 32'd0);

    // reset mid-frame, during data bit 3 of 0x35 (bit3 = 0)
    mmio_write(BASE, 8'h35);
    mmio_write(BASE, 8'hC3);
    repeat (17) begin
      @(posedge clk); #1;
    end
    check("mid_tx_before", {31'd0, tx}, 32'd0);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_tx_async", {31'd0, tx}, 32'd1);
    check("mid_busy_async", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mmio_read(BASE + 8'd2, rd);
    check("mid_level", {24'd0, rd}, 32'd0);
    check("mid_tx_idle", {31'd0, tx}, 32'd1);
    mmio_write(BASE, 8'h96);
    @(posedge clk); #1;
    check_frame(8'h96, 0);
    check("post_busy_done", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
